// File: rtl/traffic_pkg.sv
// Shared types, light encodings, config addresses and default durations
// for the intersection scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED    = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        WALK      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        DEST_NS_GREEN = 2'd0,
        DEST_EW_GREEN = 2'd1,
        DEST_WALK     = 2'd2
    } dest_t;

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

    localparam logic [1:0] CFG_GREEN  = 2'd0;
    localparam logic [1:0] CFG_YELLOW = 2'd1;
    localparam logic [1:0] CFG_ALLRED = 2'd2;
    localparam logic [1:0] CFG_WALK   = 2'd3;

    localparam logic [3:0] DEF_GREEN_CYC  = 4'd9;
    localparam logic [3:0] DEF_YELLOW_CYC = 4'd2;
    localparam logic [3:0] DEF_ALLRED_CYC = 4'd1;
    localparam logic [3:0] DEF_WALK_CYC   = 4'd6;

    // A programmed zero still gives the phase one cycle.
    function automatic logic [3:0] eff_duration(input logic [3:0] dur);
        return (dur == 4'd0) ? 4'd1 : dur;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating 4-bit phase counter; flags expiry once the phase has run
// for its effective duration.
module phase_timer
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [3:0] duration,
    output logic [3:0] count,
    output logic       expired
);

    logic [3:0] r_count;
    logic [3:0] w_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 4'd0;
        end else if (clear) begin
            r_count <= 4'd0;
        end else if (r_count != 4'hF) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign w_eff   = eff_duration(duration);
    assign count   = r_count;
    assign expired = (r_count >= (w_eff - 4'd1));

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road traffic light controller with pedestrian phase and runtime
// programmable phase durations.
module intersection_scheduler
    import traffic_pkg::*;
#(
    parameter logic [3:0] DEF_GREEN  = DEF_GREEN_CYC,
    parameter logic [3:0] DEF_YELLOW = DEF_YELLOW_CYC,
    parameter logic [3:0] DEF_ALLRED = DEF_ALLRED_CYC,
    parameter logic [3:0] DEF_WALK   = DEF_WALK_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_car,
    input  logic       ped_req,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [3:0] cfg_data,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       dontwalk,
    output logic       ped_ack
);

    state_t     r_state;
    state_t     w_next;
    dest_t      r_dest;
    dest_t      w_dest_next;
    logic       r_ped_pending;
    logic       r_ped_ack;
    logic [3:0] r_dur_green;
    logic [3:0] r_dur_yellow;
    logic [3:0] r_dur_allred;
    logic [3:0] r_dur_walk;
    logic [3:0] w_dur;
    logic [3:0] w_count;
    logic       w_expired;
    logic       w_clear;
    logic       w_walk_entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dur_green  <= DEF_GREEN;
            r_dur_yellow <= DEF_YELLOW;
            r_dur_allred <= DEF_ALLRED;
            r_dur_walk   <= DEF_WALK;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_GREEN:  r_dur_green  <= cfg_data;
                CFG_YELLOW: r_dur_yellow <= cfg_data;
                CFG_ALLRED: r_dur_allred <= cfg_data;
                default:    r_dur_walk   <= cfg_data;
            endcase
        end
    end

    always_comb begin
        w_dur = r_dur_allred;
        case (r_state)
            NS_GREEN, EW_GREEN:   w_dur = r_dur_green;
            NS_YELLOW, EW_YELLOW: w_dur = r_dur_yellow;
            WALK:                 w_dur = r_dur_walk;
            default:              w_dur = r_dur_allred;
        endcase
    end

    phase_timer u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_clear),
        .duration (w_dur),
        .count    (w_count),
        .expired  (w_expired)
    );

    always_comb begin
        w_next      = r_state;
        w_dest_next = r_dest;
        case (r_state)
            NS_GREEN: begin
                if (w_expired && (side_car || r_ped_pending)) w_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (w_expired) begin
                    w_next      = ALLRED;
                    w_dest_next = r_ped_pending ? DEST_WALK : DEST_EW_GREEN;
                end
            end
            ALLRED: begin
                if (w_expired) begin
                    case (r_dest)
                        DEST_EW_GREEN: w_next = EW_GREEN;
                        DEST_WALK:     w_next = WALK;
                        default:       w_next = NS_GREEN;
                    endcase
                end
            end
            EW_GREEN: begin
                if (w_expired) w_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (w_expired) begin
                    w_next      = ALLRED;
                    w_dest_next = DEST_NS_GREEN;
                end
            end
            WALK: begin
                if (w_expired) begin
                    w_next      = ALLRED;
                    w_dest_next = side_car ? DEST_EW_GREEN : DEST_NS_GREEN;
                end
            end
            default: begin
                w_next      = ALLRED;
                w_dest_next = DEST_NS_GREEN;
            end
        endcase
    end

    assign w_clear      = (w_next != r_state);
    assign w_walk_entry = (w_next == WALK) && (r_state != WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= NS_GREEN;
            r_dest        <= DEST_NS_GREEN;
            r_ped_pending <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dest    <= w_dest_next;
            r_ped_ack <= w_walk_entry;
            // A press on the walk-entry edge is served by this very walk phase.
            if (w_walk_entry) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req && (r_state != WALK)) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        ns_light = LIGHT_R;
        ew_light = LIGHT_R;
        walk     = 1'b0;
        dontwalk = 1'b1;
        case (r_state)
            NS_GREEN:  ns_light = LIGHT_G;
            NS_YELLOW: ns_light = LIGHT_Y;
            EW_GREEN:  ew_light = LIGHT_G;
            EW_YELLOW: ew_light = LIGHT_Y;
            WALK: begin
                walk     = 1'b1;
                dontwalk = 1'b0;
            end
            default: ;
        endcase
    end

    assign ped_ack = r_ped_ack;

    a_timer_clears: assert property (@(posedge clk) disable iff (!rst_n)
        w_clear |=> (w_count == 4'd0));

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed scenarios for intersection_scheduler; expected light states are
// queued per cycle and checked by an independent monitor.
module tb_intersection_scheduler;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic       dw;
        logic       ack;
    } obs_t;

    typedef struct packed {
        obs_t o;
        int   sc;
        int   cyc;
    } exp_t;

    localparam obs_t O_NSG  = {3'b100, 3'b001, 1'b0, 1'b1, 1'b0};
    localparam obs_t O_NSY  = {3'b010, 3'b001, 1'b0, 1'b1, 1'b0};
    localparam obs_t O_AR   = {3'b001, 3'b001, 1'b0, 1'b1, 1'b0};
    localparam obs_t O_EWG  = {3'b001, 3'b100, 1'b0, 1'b1, 1'b0};
    localparam obs_t O_EWY  = {3'b001, 3'b010, 1'b0, 1'b1, 1'b0};
    localparam obs_t O_WALK = {3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
    localparam obs_t O_WACK = {3'b001, 3'b001, 1'b1, 1'b0, 1'b1};

    logic       clk;
    logic       rst_n;
    logic       side_car;
    logic       ped_req;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_data;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       dontwalk;
    logic       ped_ack;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   sc_id    = 0;
    int   cyc_n    = 0;
    exp_t mon_e;
    obs_t mon_got;

    intersection_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .side_car (side_car),
        .ped_req  (ped_req),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .dontwalk (dontwalk),
        .ped_ack  (ped_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {ns_light, ew_light, walk, dontwalk, ped_ack};
            n_assert++;
            if (mon_got !== mon_e.o) begin
                n_fail++;
                $display("FAIL outputs sc%0d cyc%0d: got ns=%b ew=%b walk=%b dw=%b ack=%b, want ns=%b ew=%b walk=%b dw=%b ack=%b",
                         mon_e.sc, mon_e.cyc, ns_light, ew_light, walk, dontwalk, ped_ack,
                         mon_e.o.ns, mon_e.o.ew, mon_e.o.wk, mon_e.o.dw, mon_e.o.ack);
            end
        end
        n_assert++;
        if (((ns_light !== 3'b001) && (ew_light !== 3'b001)) ||
            ((walk !== 1'b0) && ((ns_light !== 3'b001) || (ew_light !== 3'b001)))) begin
            n_fail++;
            $display("FAIL safety t=%0t: got ns=%b ew=%b walk=%b, want at most one non-red and no walk unless all red",
                     $time, ns_light, ew_light, walk);
        end
    end

    task automatic run(input obs_t o, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.o   = o;
            e.sc  = sc_id;
            e.cyc = cyc_n;
            exp_q.push_back(e);
            cyc_n++;
            @(posedge clk);
            #1;
        end
    endtask

    // Asserted away from the edge so the NS_GREEN decode is seen at once.
    task automatic do_reset(input int id);
        rst_n    = 1'b0;
        side_car = 1'b0;
        ped_req  = 1'b0;
        cfg_we   = 1'b0;
        sc_id    = id;
        cyc_n    = -2;
        run(O_NSG, 2);
        rst_n = 1'b1;
        cyc_n = 0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
    endtask

    initial begin
        rst_n    = 1'b0;
        side_car = 1'b0;
        ped_req  = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = 2'd0;
        cfg_data = 4'd0;
        @(posedge clk);
        #1;

        // 1: idle, NS green held
        do_reset(1);
        run(O_NSG, 40);

        // 2: side car, full cycle with defaults
        do_reset(2);
        side_car = 1'b1;
        run(O_NSG, 9);
        run(O_NSY, 2);
        run(O_AR, 1);
        run(O_EWG, 9);
        run(O_EWY, 2);
        run(O_AR, 1);
        side_car = 1'b0;
        run(O_NSG, 3);

        // 3: pedestrian press at cycle 3
        do_reset(3);
        run(O_NSG, 3);
        ped_req = 1'b1;
        run(O_NSG, 1);
        ped_req = 1'b0;
        run(O_NSG, 5);
        run(O_NSY, 2);
        run(O_AR, 1);
        run(O_WACK, 1);
        run(O_WALK, 5);
        run(O_AR, 1);
        run(O_NSG, 3);

        // 4: ped + side car; presses on walk-entry edge and during walk dropped
        do_reset(4);
        side_car = 1'b1;
        ped_req  = 1'b1;
        run(O_NSG, 1);
        ped_req = 1'b0;
        run(O_NSG, 8);
        run(O_NSY, 2);
        ped_req = 1'b1;
        run(O_AR, 1);
        ped_req = 1'b0;
        run(O_WACK, 1);
        run(O_WALK, 1);
        ped_req = 1'b1;
        run(O_WALK, 1);
        ped_req = 1'b0;
        run(O_WALK, 3);
        run(O_AR, 1);
        run(O_EWG, 9);
        run(O_EWY, 2);
        run(O_AR, 1);
        side_car = 1'b0;
        run(O_NSG, 20);

        // 5: green=3 written at EW counter 5, then yellow=0
        do_reset(5);
        side_car = 1'b1;
        run(O_NSG, 9);
        run(O_NSY, 2);
        run(O_AR, 1);
        run(O_EWG, 5);
        cfg_write(2'd0, 4'd3);
        run(O_EWG, 1);
        cfg_we = 1'b0;
        run(O_EWG, 1);
        run(O_EWY, 2);
        run(O_AR, 1);
        cfg_write(2'd1, 4'd0);
        run(O_NSG, 1);
        cfg_we = 1'b0;
        run(O_NSG, 2);
        run(O_NSY, 1);
        run(O_AR, 1);
        run(O_EWG, 3);
        run(O_EWY, 1);
        run(O_AR, 1);
        side_car = 1'b0;
        run(O_NSG, 5);

        // 6: reset mid-walk, then reset with a press pending
        do_reset(6);
        ped_req = 1'b1;
        run(O_NSG, 1);
        ped_req = 1'b0;
        run(O_NSG, 8);
        run(O_NSY, 2);
        run(O_AR, 1);
        run(O_WACK, 1);
        run(O_WALK, 2);
        do_reset(6);
        run(O_NSG, 2);
        ped_req = 1'b1;
        run(O_NSG, 1);
        ped_req = 1'b0;
        run(O_NSG, 1);
        do_reset(7);
        run(O_NSG, 20);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
